// File: rtl/sd2pwm_multi.sv
// sd2pwm_multi
// Converts NCH independent sigma-delta bitstreams into PWM outputs. Each
// channel works as a second-order loop:
//   int1 integrates the incoming bitstream (+1/-1 per edge),
//   int2 integrates the channel's own PWM output (+1/-1 per edge),
//   err  is the registered difference int1 - int2,
//   pwm  comes from a hysteresis comparator on err.
// Both integrators saturate symmetrically. A sticky per-channel flag records
// that clipping occurred.
//
// Ports:
//   clk      - single clock; all state changes on the rising edge
//   rst_n    - synchronous active-low reset; overrides every other control
//   en       - advance enable; when low, all channel state holds
//   clr      - synchronous clear of int1/int2/err/pwm (sat flags untouched)
//   sat_clr  - synchronous clear of the sticky saturation flags
//   sd_bs    - one bitstream bit per channel (1 = +1, 0 = -1)
//   pwm      - registered PWM output per channel
//   sat      - registered sticky saturation flag per channel
module sd2pwm_multi #(
  parameter int NCH    = 2,
  parameter int WIDTH  = 16,
  parameter int THRESH = 32,
  parameter int HYST   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           clr,
  input  logic           sat_clr,
  input  logic [NCH-1:0] sd_bs,
  output logic [NCH-1:0] pwm,
  output logic [NCH-1:0] sat
);

  // One extra bit holds both the unclipped integrator sums and the
  // int1 - int2 difference without overflow.
  localparam int EW = WIDTH + 1;

  // Symmetric clip limits: the most negative WIDTH-bit code is never produced.
  localparam logic signed [EW-1:0] SAT_MAX = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = -SAT_MAX;

  localparam logic signed [EW-1:0] STEP_UP = {{(EW-1){1'b0}}, 1'b1};
  localparam logic signed [EW-1:0] STEP_DN = {EW{1'b1}};

  // Comparator band edges, sign-extended to the error width.
  localparam logic signed [EW-1:0] TH_HI = EW'(THRESH + HYST);
  localparam logic signed [EW-1:0] TH_LO = EW'(THRESH - HYST);

  logic signed [WIDTH-1:0] int1_q [NCH];
  logic signed [WIDTH-1:0] int1_d [NCH];
  logic signed [WIDTH-1:0] int2_q [NCH];
  logic signed [WIDTH-1:0] int2_d [NCH];
  logic signed [EW-1:0]    err_q  [NCH];
  logic signed [EW-1:0]    err_d  [NCH];
  logic [NCH-1:0]          pwm_q, pwm_d;
  logic [NCH-1:0]          sat_q, sat_d;

  logic signed [EW-1:0]    sum1   [NCH];
  logic signed [EW-1:0]    sum2   [NCH];
  logic signed [EW-1:0]    lim1   [NCH];
  logic signed [EW-1:0]    lim2   [NCH];
  logic signed [EW-1:0]    diff   [NCH];
  logic [NCH-1:0]          clip1, clip2;

  // Per-channel datapath: widened sums, clipping, difference and the
  // hysteresis comparator. Channels share nothing but the control inputs.
  always_comb begin
    int1_d = int1_q;
    int2_d = int2_q;
    err_d  = err_q;
    pwm_d  = pwm_q;
    sat_d  = sat_q;
    clip1  = '0;
    clip2  = '0;
    for (int i = 0; i < NCH; i++) begin
      sum1[i] = {int1_q[i][WIDTH-1], int1_q[i]} + (sd_bs[i] ? STEP_UP : STEP_DN);
      sum2[i] = {int2_q[i][WIDTH-1], int2_q[i]} + (pwm_q[i] ? STEP_UP : STEP_DN);
      diff[i] = {int1_q[i][WIDTH-1], int1_q[i]} - {int2_q[i][WIDTH-1], int2_q[i]};

      lim1[i] = sum1[i];
      if (sum1[i] > SAT_MAX) begin
        lim1[i]  = SAT_MAX;
        clip1[i] = 1'b1;
      end else if (sum1[i] < SAT_MIN) begin
        lim1[i]  = SAT_MIN;
        clip1[i] = 1'b1;
      end

      lim2[i] = sum2[i];
      if (sum2[i] > SAT_MAX) begin
        lim2[i]  = SAT_MAX;
        clip2[i] = 1'b1;
      end else if (sum2[i] < SAT_MIN) begin
        lim2[i]  = SAT_MIN;
        clip2[i] = 1'b1;
      end

      if (clr) begin
        int1_d[i] = '0;
        int2_d[i] = '0;
        err_d[i]  = '0;
        pwm_d[i]  = 1'b0;
      end else if (en) begin
        int1_d[i] = lim1[i][WIDTH-1:0];
        int2_d[i] = lim2[i][WIDTH-1:0];
        err_d[i]  = diff[i];
        if (err_q[i] > TH_HI) begin
          pwm_d[i] = 1'b1;
        end else if (err_q[i] < TH_LO) begin
          pwm_d[i] = 1'b0;
        end
      end

      // A clip on this edge beats a simultaneous flag clear.
      if (sat_clr) begin
        sat_d[i] = 1'b0;
      end
      if (en && !clr && (clip1[i] || clip2[i])) begin
        sat_d[i] = 1'b1;
      end
    end
  end

  // State register; reset wins over every other control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        int1_q[i] <= '0;
        int2_q[i] <= '0;
        err_q[i]  <= '0;
      end
      pwm_q <= '0;
      sat_q <= '0;
    end else begin
      int1_q <= int1_d;
      int2_q <= int2_d;
      err_q  <= err_d;
      pwm_q  <= pwm_d;
      sat_q  <= sat_d;
    end
  end

  assign pwm = pwm_q;
  assign sat = sat_q;

endmodule

// File: tb/tb_sd2pwm_multi.sv
// Testbench for sd2pwm_multi. Two instances run side by side: one with the
// default parameters and one narrow (WIDTH=8, THRESH=-200) so that
// saturation is reachable in a few hundred cycles. A behavioural model using
// plain integer arithmetic tracks both and is compared every cycle; directed
// phases add hand-derived literal expectations.
module tb_sd2pwm_multi;

  localparam int NCH  = 2;
  localparam int WB   = 8;
  localparam int THB  = -200;
  localparam int HYB  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, en, clr, sat_clr;
  logic [NCH-1:0] sd_a, sd_b;
  logic [NCH-1:0] pwm_a, sat_a, pwm_b, sat_b;

  int checks   = 0;
  int failures = 0;

  // Model state indexed [instance][channel].
  longint m_i1  [2][2];
  longint m_i2  [2][2];
  longint m_err [2][2];
  bit     m_pwm [2][2];
  bit     m_sat [2][2];
  bit     m_valid = 1'b0;
  longint lim [2];
  longint thi [2];
  longint tlo [2];

  sd2pwm_multi #(.NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .sat_clr(sat_clr),
    .sd_bs(sd_a), .pwm(pwm_a), .sat(sat_a)
  );

  sd2pwm_multi #(.NCH(NCH), .WIDTH(WB), .THRESH(THB), .HYST(HYB)) dut_w8 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .sat_clr(sat_clr),
    .sd_bs(sd_b), .pwm(pwm_b), .sat(sat_b)
  );

  initial begin
    lim[0] = (longint'(1) << 15) - 1;
    lim[1] = (longint'(1) << (WB - 1)) - 1;
    thi[0] = 32 + 4;
    tlo[0] = 32 - 4;
    thi[1] = THB + HYB;
    tlo[1] = THB - HYB;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 2; c++) begin
        m_i1[k][c] = 0; m_i2[k][c] = 0; m_err[k][c] = 0;
        m_pwm[k][c] = 0; m_sat[k][c] = 0;
      end
    end
  end

  function automatic logic [1:0] mPwm(input int k);
    return {m_pwm[k][1], m_pwm[k][0]};
  endfunction

  function automatic logic [1:0] mSat(input int k);
    return {m_sat[k][1], m_sat[k][0]};
  endfunction

  task automatic cmp2(input string nm, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmpInt(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Apply one edge of the channel rules to instance k using the inputs
  // present at the rising edge.
  task automatic modelStep(input logic [1:0] bs, input int k);
    longint n1, n2;
    bit     c, np;
    for (int ch = 0; ch < 2; ch++) begin
      if (!rst_n) begin
        m_i1[k][ch] = 0; m_i2[k][ch] = 0; m_err[k][ch] = 0;
        m_pwm[k][ch] = 0; m_sat[k][ch] = 0;
      end else begin
        c = 0;
        if (clr) begin
          m_i1[k][ch] = 0; m_i2[k][ch] = 0; m_err[k][ch] = 0; m_pwm[k][ch] = 0;
        end else if (en) begin
          n1 = m_i1[k][ch] + (bs[ch] ? 1 : -1);
          n2 = m_i2[k][ch] + (m_pwm[k][ch] ? 1 : -1);
          if (n1 > lim[k])  begin n1 = lim[k];  c = 1; end
          if (n1 < -lim[k]) begin n1 = -lim[k]; c = 1; end
          if (n2 > lim[k])  begin n2 = lim[k];  c = 1; end
          if (n2 < -lim[k]) begin n2 = -lim[k]; c = 1; end
          if (m_err[k][ch] > thi[k])      np = 1;
          else if (m_err[k][ch] < tlo[k]) np = 0;
          else                            np = m_pwm[k][ch];
          m_err[k][ch] = m_i1[k][ch] - m_i2[k][ch];
          m_i1[k][ch]  = n1;
          m_i2[k][ch]  = n2;
          m_pwm[k][ch] = np;
        end
        if (sat_clr) m_sat[k][ch] = 0;
        if (c)       m_sat[k][ch] = 1;
      end
    end
  endtask

  task automatic checkOutput();
    cmp2("model_pwm_a", pwm_a, mPwm(0));
    cmp2("model_sat_a", sat_a, mSat(0));
    cmp2("model_pwm_b", pwm_b, mPwm(1));
    cmp2("model_sat_b", sat_b, mSat(1));
  endtask

  // Model update on every rising edge, comparison 1 time unit later.
  always begin
    @(posedge clk);
    if (!rst_n) m_valid = 1'b1;
    if (m_valid) begin
      modelStep(sd_a, 0);
      modelStep(sd_b, 1);
    end
    #1;
    if (m_valid) checkOutput();
  end

  // Drive one edge worth of inputs, then return 2 units after that edge.
  task automatic applyStimulus(input logic rn, input logic e, input logic c,
                               input logic sc, input logic [1:0] a,
                               input logic [1:0] b);
    rst_n   = rn;
    en      = e;
    clr     = c;
    sat_clr = sc;
    sd_a    = a;
    sd_b    = b;
    @(posedge clk);
    #2;
  endtask

  int dens [2];
  logic [1:0] ra, rb;

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; sat_clr = 1'b0; sd_a = '0; sd_b = '0;
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    cmp2("reset_pwm_a", pwm_a, 2'b00);
    cmp2("reset_sat_a", sat_a, 2'b00);
    cmp2("reset_pwm_b", pwm_b, 2'b00);
    cmp2("reset_sat_b", sat_b, 2'b00);

    // Full-scale positive input from reset: pwm first rises after edge 21.
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00);
      if (k == 20) cmp2("ramp_pwm_e20", pwm_a, 2'b00);
      if (k == 21) begin
        cmp2("ramp_pwm_e21", pwm_a, 2'b11);
        cmpInt("model_int1_e21", m_i1[0][0], 21);
        cmpInt("model_err_e21", m_err[0][0], 40);
      end
    end

    // Clear mid-stream, then the same ramp must repeat exactly.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 2'b00);
    cmp2("clr_pwm_a", pwm_a, 2'b00);
    cmp2("clr_pwm_b", pwm_b, 2'b00);
    for (int k = 1; k <= 21; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00);
      if (k == 20) cmp2("reramp_pwm_e20", pwm_a, 2'b00);
      if (k == 21) cmp2("reramp_pwm_e21", pwm_a, 2'b11);
    end

    // Alternating input from a cleared state stays well under threshold.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    for (int k = 0; k < 10; k++)
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, (k % 2 == 0) ? 2'b11 : 2'b00, 2'b00);
    cmp2("alt_pwm_a", pwm_a, 2'b00);
    cmp2("alt_sat_a", sat_a, 2'b00);

    // Narrow instance: ch0 held high, ch1 alternating, pwm forced high.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00);
    for (int k = 1; k <= 128; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, {logic'(k % 2 == 1), 1'b1});
      if (k == 127) begin
        cmpInt("w8_int1_e127", m_i1[1][0], 127);
        cmp2("w8_sat_e127", sat_b, 2'b00);
      end
      if (k == 128) cmp2("w8_sat_e128", sat_b, 2'b01);
    end
    // Clip on ch0 with sat_clr on the same edge: set wins.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b11);
    cmp2("w8_setwins_e129", sat_b, 2'b01);
    // Both int2 integrators reach the limit and clip on this edge.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b01);
    cmp2("w8_int2clip_e130", sat_b, 2'b11);
    // sat_clr still acts while en is low.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01);
    cmp2("w8_satclr_en0", sat_b, 2'b00);
    cmp2("w8_pwm_en0", pwm_b, 2'b11);

    // Randomized run with occasional en gaps, clears and resets.
    dens[0] = 70; dens[1] = 30;
    rb = 2'b01;
    for (int n = 0; n < 3000; n++) begin
      if (n % 97 == 0) begin
        dens[0] = int'($urandom_range(0, 100));
        dens[1] = int'($urandom_range(0, 100));
      end
      ra[0] = ($urandom_range(0, 99) < dens[0]);
      ra[1] = ($urandom_range(0, 99) < dens[1]);
      if ($urandom_range(0, 199) == 0) rb[0] = ~rb[0];
      if ($urandom_range(0, 199) == 0) rb[1] = ~rb[1];
      applyStimulus(logic'($urandom_range(0, 999) != 0),
                    logic'($urandom_range(0, 9) != 0),
                    logic'($urandom_range(0, 199) == 0),
                    logic'($urandom_range(0, 39) == 0),
                    ra, rb);
    end

    // Reset with en high and clr low zeroes everything on the next edge.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b11);
    cmp2("final_rst_pwm_a", pwm_a, 2'b00);
    cmp2("final_rst_sat_a", sat_a, 2'b00);
    cmp2("final_rst_pwm_b", pwm_b, 2'b00);
    cmp2("final_rst_sat_b", sat_b, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
